// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and a width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

  // Smallest width able to hold the values 0..value-1.
  function automatic int CeilLog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_tick_ctrl_if.sv
// Button inputs and counter strobes of the stopwatch tick controller.
interface stopwatch_tick_ctrl_if;

  logic start_stop_btn;
  logic clear_btn;
  logic enb;
  logic sync_rst_enb;
  logic running;

  modport master (
    output start_stop_btn,
    output clear_btn,
    input  enb,
    input  sync_rst_enb,
    input  running
  );

  modport slave (
    input  start_stop_btn,
    input  clear_btn,
    output enb,
    output sync_rst_enb,
    output running
  );

endinterface

// File: rtl/tick_prescaler.sv
// Prescaler dividing clk down to one tick every DIV cycles; holds while not
// running so a paused partial period resumes where it left off.
module tick_prescaler #(
  parameter int DIV         = 10,
  parameter int NBitsForDiv = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [NBitsForDiv-1:0] LAST = NBitsForDiv'(DIV - 1);

  logic [NBitsForDiv-1:0] div_cnt;

  // Tick is the last count of a period while running.
  assign tick = run & (div_cnt == LAST);

  // Count while running, wrap at DIV-1, hold otherwise; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// Stopwatch control stage: synchronises the push buttons, runs the
// IDLE/RUN/PAUSE state machine and produces the counter enb/sync_rst_enb
// strobes from a gated prescaler tick.
module stopwatch_tick_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int TICK_FREQ_HZ = 100,
  parameter int NBitsForDiv  = CeilLog2(CLK_FREQ_HZ / TICK_FREQ_HZ)
) (
  input  logic                  clk,
  input  logic                  rst,
  stopwatch_tick_ctrl_if.slave  bus
);

  localparam int DIV = CLK_FREQ_HZ / TICK_FREQ_HZ;

  if (DIV < 2) begin : g_div_check
    $error("stopwatch_tick_ctrl: CLK_FREQ_HZ/TICK_FREQ_HZ must be at least 2");
  end

  // [0]=first sync flop, [1]=second sync flop, [2]=edge-detect history.
  logic [2:0] ss_sync;
  logic [2:0] clr_sync;
  logic       ss_rise;
  logic       clr_rise;

  sw_state_t state;
  sw_state_t state_next;
  logic      enb_next;
  logic      sre_next;
  logic      run_cnt;
  logic      clr_cnt;
  logic      tick;

  // Two-flop synchronisers plus one history flop per button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync  <= '0;
      clr_sync <= '0;
    end else begin
      ss_sync  <= {ss_sync[1:0], bus.start_stop_btn};
      clr_sync <= {clr_sync[1:0], bus.clear_btn};
    end
  end

  assign ss_rise  = ss_sync[1] & ~ss_sync[2];
  assign clr_rise = clr_sync[1] & ~clr_sync[2];

  // The prescaler only advances in RUN and is zeroed in IDLE or on clear.
  assign run_cnt = (state == RUN);
  assign clr_cnt = clr_rise | (state == IDLE);

  tick_prescaler #(
    .DIV         (DIV),
    .NBitsForDiv (NBitsForDiv)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run_cnt),
    .clr  (clr_cnt),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and strobes; clear overrides both start/stop and the tick.
  always_comb begin
    state_next = state;
    enb_next   = tick;
    sre_next   = 1'b0;
    if (clr_rise) begin
      state_next = IDLE;
      enb_next   = 1'b1;
      sre_next   = 1'b1;
    end else if (ss_rise) begin
      unique case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Registered outputs; running tracks the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.enb          <= 1'b0;
      bus.sync_rst_enb <= 1'b0;
      bus.running      <= 1'b0;
    end else begin
      bus.enb          <= enb_next;
      bus.sync_rst_enb <= sre_next;
      bus.running      <= (state_next == RUN);
    end
  end

endmodule
